// File: rtl/wfq_pkg.sv
// wfq_pkg: shared widths, FSM encoding and constants for the WFQ divide stage.
// Included by wfq_div_stage and wfq_seq_divider.
package wfq_pkg;

    localparam int DEF_CLASS_WIDTH  = 5;
    localparam int DEF_WEIGHT_WIDTH = 16;
    localparam int DEF_PKT_WIDTH    = 16;
    localparam int CLASS_ID_COUNT   = 2 ** DEF_CLASS_WIDTH;

    localparam int WEIGHT_RESET = 1;

    localparam logic [DEF_WEIGHT_WIDTH-1:0] QUOTIENT_SAT = '1;

    typedef enum logic {
        IDLE = 1'b0,
        DIV  = 1'b1
    } state_t;

endpackage

// File: rtl/wfq_seq_divider.sv
// wfq_seq_divider: radix-2 restoring divider, one dividend bit per cycle, MSB first.
// done and the result ports are valid in the cycle of the final iteration.
module wfq_seq_divider
    import wfq_pkg::*;
#(
    parameter int N = DEF_PKT_WIDTH,
    parameter int W = DEF_WEIGHT_WIDTH
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CNT_W = $clog2(N + 1);

    logic             active;
    logic [CNT_W-1:0] cnt;
    logic [W:0]       rem;
    logic [W:0]       rem_shift;
    logic [W:0]       rem_next;
    logic [N-1:0]     dvd;
    logic [N-1:0]     quo;
    logic [N-1:0]     quo_next;
    logic [W-1:0]     dsr;
    logic             ge;

    assign rem_shift = (rem << 1) | {{W{1'b0}}, dvd[N-1]};
    assign ge        = (rem_shift >= {1'b0, dsr});
    assign rem_next  = ge ? (rem_shift - {1'b0, dsr}) : rem_shift;
    assign quo_next  = (quo << 1) | N'(ge);

    assign done      = active && (cnt == CNT_W'(N - 1));
    assign quotient  = W'(quo_next);
    assign remainder = rem_next[W-1:0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            active <= 1'b0;
            cnt    <= '0;
            rem    <= '0;
            dvd    <= '0;
            quo    <= '0;
            dsr    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            rem    <= '0;
            dvd    <= dividend;
            quo    <= '0;
            dsr    <= divisor;
        end else if (active) begin
            rem <= rem_next;
            dvd <= dvd << 1;
            quo <= quo_next;
            cnt <= cnt + 1'b1;
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/wfq_div_stage.sv
// wfq_div_stage: per-class weight lookup and pkt_len/weight division for the WFQ engine.
// Define WFQ_DIV_POW2_FASTPATH_EN for single-cycle results on power-of-two weights.
module wfq_div_stage
    import wfq_pkg::*;
#(
    parameter int CLASS_WIDTH  = DEF_CLASS_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int PKT_WIDTH    = DEF_PKT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [CLASS_WIDTH-1:0]  req_class_id,
    input  logic [PKT_WIDTH-1:0]    req_pkt_len,
    input  logic                    cfg_wr_en,
    input  logic [CLASS_WIDTH-1:0]  cfg_class_id,
    input  logic [WEIGHT_WIDTH-1:0] cfg_weight,
    output logic                    div_valid,
    output logic [CLASS_WIDTH-1:0]  div_class_id,
    output logic [WEIGHT_WIDTH-1:0] div_quotient,
    output logic [WEIGHT_WIDTH-1:0] div_remain
);

    localparam int N_CLASS = 2 ** CLASS_WIDTH;

    logic [WEIGHT_WIDTH-1:0] wtab [N_CLASS];
    state_t                  state;
    logic [CLASS_WIDTH-1:0]  cls_q;
    logic [WEIGHT_WIDTH-1:0] w_rd;
    logic                    accept;
    logic                    w_zero;
    logic                    fast;
    logic                    start;
    logic                    div_done;
    logic [WEIGHT_WIDTH-1:0] fast_q;
    logic [WEIGHT_WIDTH-1:0] fast_r;
    logic [WEIGHT_WIDTH-1:0] core_q;
    logic [WEIGHT_WIDTH-1:0] core_r;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign w_rd      = wtab[req_class_id];
    assign w_zero    = (w_rd == '0);

`ifdef WFQ_DIV_POW2_FASTPATH_EN
    assign fast   = !w_zero && ((w_rd & (w_rd - 1'b1)) == '0);
    assign fast_r = WEIGHT_WIDTH'(req_pkt_len) & (w_rd - 1'b1);

    always_comb begin
        fast_q = '0;
        for (int i = 0; i < WEIGHT_WIDTH; i++) begin
            if (w_rd[i]) begin
                fast_q = WEIGHT_WIDTH'(req_pkt_len) >> i;
            end
        end
    end
`else
    assign fast   = 1'b0;
    assign fast_q = '0;
    assign fast_r = '0;
`endif

    assign start = accept && !w_zero && !fast;

    wfq_seq_divider #(
        .N (PKT_WIDTH),
        .W (WEIGHT_WIDTH)
    ) u_div (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .dividend  (req_pkt_len),
        .divisor   (w_rd),
        .done      (div_done),
        .quotient  (core_q),
        .remainder (core_r)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            cls_q        <= '0;
            div_valid    <= 1'b0;
            div_class_id <= '0;
            div_quotient <= '0;
            div_remain   <= '0;
            for (int i = 0; i < N_CLASS; i++) begin
                wtab[i] <= WEIGHT_WIDTH'(WEIGHT_RESET);
            end
        end else begin
            div_valid <= 1'b0;
            // Table read above sees the pre-write value on a same-cycle hit.
            if (cfg_wr_en) begin
                wtab[cfg_class_id] <= cfg_weight;
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cls_q <= req_class_id;
                        if (w_zero || fast) begin
                            div_valid    <= 1'b1;
                            div_class_id <= req_class_id;
                            div_quotient <= w_zero ? '1 : fast_q;
                            div_remain   <= w_zero ? '0 : fast_r;
                        end else begin
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    if (div_done) begin
                        div_valid    <= 1'b1;
                        div_class_id <= cls_q;
                        div_quotient <= core_q;
                        div_remain   <= core_r;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wfq_div_stage.sv
// tb_wfq_div_stage: directed plus randomized requests against a queue-based
// arithmetic model of the divide stage, checked on every cycle.
module tb_wfq_div_stage;
    import wfq_pkg::*;

    localparam int CW  = DEF_CLASS_WIDTH;
    localparam int WW  = DEF_WEIGHT_WIDTH;
    localparam int PW  = DEF_PKT_WIDTH;
    localparam int LAT = PW + 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [CW-1:0] req_class_id = '0;
    logic [PW-1:0] req_pkt_len = '0;
    logic          cfg_wr_en = 1'b0;
    logic [CW-1:0] cfg_class_id = '0;
    logic [WW-1:0] cfg_weight = '0;
    logic          div_valid;
    logic [CW-1:0] div_class_id;
    logic [WW-1:0] div_quotient;
    logic [WW-1:0] div_remain;

    wfq_div_stage dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_class_id (req_class_id),
        .req_pkt_len  (req_pkt_len),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_class_id (cfg_class_id),
        .cfg_weight   (cfg_weight),
        .div_valid    (div_valid),
        .div_class_id (div_class_id),
        .div_quotient (div_quotient),
        .div_remain   (div_remain)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     due;
        int     cls;
        longint q;
        longint r;
    } exp_t;

    exp_t   eq[$];
    longint wt[2**CW];
    int     busy_until = 0;
    bit     armed = 0;
    int     last_cls = 0;
    longint last_q = 0;
    longint last_r = 0;

    bit     exp_v;
    longint m_w;
    longint m_len;
    int     m_lat;
    exp_t   m_e;

    task automatic chk(input string nm, input logic [63:0] act, input longint exp);
        total++;
        if (act !== 64'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: expected results from plain integer / and %.
    always @(negedge clk) begin
        if (armed) begin
            while (eq.size() > 0 && eq[0].due < cyc) begin
                void'(eq.pop_front());
            end
            exp_v = (eq.size() > 0) && (eq[0].due == cyc);
            chk("req_ready", 64'(req_ready), longint'(cyc >= busy_until));
            chk("div_valid", 64'(div_valid), longint'(exp_v));
            if (exp_v) begin
                last_cls = eq[0].cls;
                last_q   = eq[0].q;
                last_r   = eq[0].r;
                void'(eq.pop_front());
            end
            chk("div_class_id", 64'(div_class_id), longint'(last_cls));
            chk("div_quotient", 64'(div_quotient), last_q);
            chk("div_remain", 64'(div_remain), last_r);
        end
        if (!rstn) begin
            eq.delete();
            foreach (wt[i]) wt[i] = 1;
            busy_until = cyc + 1;
            last_cls = 0;
            last_q = 0;
            last_r = 0;
            armed = 1;
        end else if (armed) begin
            if (req_valid && cyc >= busy_until) begin
                m_w   = longint'(wt[req_class_id]);
                m_len = longint'(req_pkt_len);
                if (m_w == 0) begin
                    m_e.q = (longint'(1) << WW) - 1;
                    m_e.r = 0;
                    m_lat = 1;
                end else begin
                    m_e.q = m_len / m_w;
                    m_e.r = m_len % m_w;
                    m_lat = LAT;
`ifdef WFQ_DIV_POW2_FASTPATH_EN
                    if ((m_w & (m_w - 1)) == 0) m_lat = 1;
`endif
                end
                m_e.due = cyc + m_lat;
                m_e.cls = int'(req_class_id);
                eq.push_back(m_e);
                busy_until = cyc + m_lat;
            end
            if (cfg_wr_en) wt[cfg_class_id] = longint'(cfg_weight);
        end
    end

    task automatic do_req(input int c, input int l, input bit hold);
        int n = 0;
        req_class_id = CW'(c);
        req_pkt_len  = PW'(l);
        req_valid    = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: ready=0 after %0d cycles want 1", n);
        end
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((eq.size() != 0 || cyc < busy_until) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (eq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL wait_idle: %0d results pending want 0", eq.size());
        end
    endtask

    task automatic cfg_write(input int c, input int w);
        cfg_wr_en    = 1'b1;
        cfg_class_id = CW'(c);
        cfg_weight   = WW'(w);
        @(posedge clk);
        #1;
        cfg_wr_en = 1'b0;
    endtask

    function automatic int rand_w();
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return 1;
            2:       return 1 << $urandom_range(1, WW - 1);
            3:       return 3;
            4:       return (1 << WW) - 1;
            default: return int'($urandom_range(1, (1 << WW) - 1));
        endcase
    endfunction

    function automatic int rand_len();
        case ($urandom_range(0, 4))
            0:       return 0;
            1:       return (1 << PW) - 1;
            default: return int'($urandom_range(0, (1 << PW) - 1));
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        do_req(3, 100, 0);
        wait_idle();
        chk("t1_quotient", 64'(div_quotient), 100);
        chk("t1_remain", 64'(div_remain), 0);
        chk("t1_class", 64'(div_class_id), 3);

        cfg_write(5, 7);
        do_req(5, 1500, 0);
        wait_idle();
        chk("t2_quotient", 64'(div_quotient), 214);
        chk("t2_remain", 64'(div_remain), 2);

        cfg_write(2, 0);
        do_req(2, 64, 0);
        wait_idle();
        chk("t3_quotient", 64'(div_quotient), 65535);
        chk("t3_remain", 64'(div_remain), 0);

        cfg_wr_en    = 1'b1;
        cfg_class_id = CW'(4);
        cfg_weight   = WW'(3);
        do_req(4, 10, 0);
        cfg_wr_en = 1'b0;
        wait_idle();
        chk("t4a_quotient", 64'(div_quotient), 10);
        chk("t4a_remain", 64'(div_remain), 0);
        do_req(4, 10, 0);
        wait_idle();
        chk("t4b_quotient", 64'(div_quotient), 3);
        chk("t4b_remain", 64'(div_remain), 1);

        cfg_write(1, 1000);
        do_req(1, 65535, 1);
        do_req(1, 999, 0);
        chk("t5a_quotient", 64'(div_quotient), 65);
        chk("t5a_remain", 64'(div_remain), 535);
        wait_idle();
        chk("t5b_quotient", 64'(div_quotient), 0);
        chk("t5b_remain", 64'(div_remain), 999);

        do_req(1, 999, 0);
        repeat (4) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("t6_ready", 64'(req_ready), 1);
        chk("t6_valid", 64'(div_valid), 0);
        do_req(1, 9, 0);
        wait_idle();
        chk("t6_quotient", 64'(div_quotient), 9);
        chk("t6_remain", 64'(div_remain), 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                cfg_wr_en    = 1'b1;
                cfg_class_id = CW'($urandom_range(0, 7));
                cfg_weight   = WW'(rand_w());
            end
            do_req(int'($urandom_range(0, 7)), rand_len(), 1'($urandom_range(0, 1)));
            cfg_wr_en = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                if ($urandom_range(0, 1) == 1) begin
                    cfg_wr_en    = 1'b1;
                    cfg_class_id = CW'($urandom_range(0, 7));
                    cfg_weight   = WW'(rand_w());
                end
                @(posedge clk);
                #1;
                cfg_wr_en = 1'b0;
            end
        end
        req_valid = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
